// File: rtl/ads1115_i2c_responder_if.sv
// Register-side bundle for the ADS1115 responder: bus clock in, conversion data in, register view out.
// The open-drain sda line stays a plain inout on the responder so it can be resolved at the top.
interface ads1115_i2c_responder_if;
    logic        scl;
    logic [15:0] conv_data;
    logic [1:0]  pointer;
    logic [15:0] config_reg;
    logic        cfg_wr;
    logic        busy;

    modport slave (
        input  scl, conv_data,
        output pointer, config_reg, cfg_wr, busy
    );

    modport master (
        output scl, conv_data,
        input  pointer, config_reg, cfg_wr, busy
    );
endinterface

// File: rtl/ads1115_i2c_responder.sv
// I2C target emulating the ADS1115 pointer/config/conversion register map.
// Define I2C_RESP_GLITCH_FILTER_EN to add a 3-sample majority filter after each synchronizer.
module ads1115_i2c_responder #(
    parameter logic [6:0]  ADDR      = 7'h48,
    parameter logic [15:0] CFG_RESET = 16'h8583
) (
    input  logic                   clk,
    input  logic                   rst,
    inout  wire                    sda,
    ads1115_i2c_responder_if.slave bus
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
        StWdata, StWdataAck, StRdata, StRack, StIgnore
    } state_e;

    logic [1:0]  scl_meta, sda_meta;
    logic        scl_f, sda_f, scl_prev, sda_prev;
    logic        scl_rise, scl_fall, start_det, stop_det;
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shreg_q, shreg_d, msb_q, msb_d;
    logic [15:0] tx_q, tx_d, config_q, config_d, shadow, config_rd;
    logic        lsb_phase_q, lsb_phase_d, ack_q, ack_d, sda_low_q, sda_low_d;
    logic        busy_q, busy_d, cfg_wr_q, cfg_wr_d, addr_match;
    logic [1:0]  pointer_q, pointer_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_meta <= 2'b11;
            sda_meta <= 2'b11;
        end else begin
            scl_meta <= {scl_meta[0], bus.scl};
            sda_meta <= {sda_meta[0], sda};
        end
    end

`ifdef I2C_RESP_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_meta[1]};
            sda_hist <= {sda_hist[0], sda_meta[1]};
            scl_f    <= (scl_meta[1] & scl_hist[0]) | (scl_meta[1] & scl_hist[1]) |
                        (scl_hist[0] & scl_hist[1]);
            sda_f    <= (sda_meta[1] & sda_hist[0]) | (sda_meta[1] & sda_hist[1]) |
                        (sda_hist[0] & sda_hist[1]);
        end
    end
`else
    assign scl_f = scl_meta[1];
    assign sda_f = sda_meta[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_f;
            sda_prev <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_prev;
    assign scl_fall  = ~scl_f & scl_prev;
    assign start_det = scl_f & scl_prev & sda_prev & ~sda_f;
    assign stop_det  = scl_f & scl_prev & ~sda_prev & sda_f;

    // OS bit always reads back as 1.
    assign config_rd  = config_q | 16'h8000;
    assign addr_match = (shreg_q[7:1] == ADDR);

    always_comb begin
        unique case (pointer_q)
            2'd0:    shadow = bus.conv_data;
            2'd1:    shadow = config_rd;
            2'd2:    shadow = 16'h8000;
            default: shadow = 16'h7FFF;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        tx_d        = tx_q;
        msb_d       = msb_q;
        lsb_phase_d = lsb_phase_q;
        ack_d       = ack_q;
        sda_low_d   = sda_low_q;
        busy_d      = busy_q;
        pointer_d   = pointer_q;
        config_d    = config_q;
        cfg_wr_d    = 1'b0;
        if (start_det) begin
            state_d     = StAddr;
            cnt_d       = '0;
            busy_d      = 1'b1;
            sda_low_d   = 1'b0;
            lsb_phase_d = 1'b0;
        end else if (stop_det) begin
            state_d   = StIdle;
            busy_d    = 1'b0;
            sda_low_d = 1'b0;
        end else begin
            unique case (state_q)
                StAddr, StPtr, StWdata: begin
                    if (scl_rise) begin
                        shreg_d = {shreg_q[6:0], sda_f};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d     = '0;
                        sda_low_d = 1'b1;
                        if (state_q == StAddr) begin
                            state_d   = StAddrAck;
                            sda_low_d = addr_match;
                            tx_d      = shadow;
                        end else if (state_q == StPtr) begin
                            state_d = StPtrAck;
                        end else begin
                            state_d = StWdataAck;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        sda_low_d = 1'b0;
                        if (!addr_match) begin
                            state_d = StIgnore;
                        end else if (shreg_q[0]) begin
                            state_d   = StRdata;
                            sda_low_d = ~tx_q[15];
                        end else begin
                            state_d = StPtr;
                        end
                    end
                end
                StPtrAck: begin
                    if (scl_fall) begin
                        pointer_d   = shreg_q[1:0];
                        lsb_phase_d = 1'b0;
                        sda_low_d   = 1'b0;
                        state_d     = StWdata;
                    end
                end
                StWdataAck: begin
                    if (scl_fall) begin
                        sda_low_d   = 1'b0;
                        state_d     = StWdata;
                        lsb_phase_d = ~lsb_phase_q;
                        if (!lsb_phase_q) begin
                            msb_d = shreg_q;
                        end else if (pointer_q == 2'd1) begin
                            config_d = {msb_q, shreg_q};
                            cfg_wr_d = 1'b1;
                        end
                    end
                end
                StRdata: begin
                    // Rotating the word means the next byte's MSB is on top after 8 bits.
                    if (scl_fall) begin
                        tx_d = {tx_q[14:0], tx_q[15]};
                        if (cnt_q == 4'd7) begin
                            cnt_d     = '0;
                            sda_low_d = 1'b0;
                            state_d   = StRack;
                        end else begin
                            cnt_d     = cnt_q + 4'd1;
                            sda_low_d = ~tx_q[14];
                        end
                    end
                end
                StRack: begin
                    if (scl_rise) begin
                        ack_d = ~sda_f;
                    end else if (scl_fall) begin
                        if (ack_q) begin
                            state_d   = StRdata;
                            sda_low_d = ~tx_q[15];
                        end else begin
                            state_d = StIgnore;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shreg_q     <= '0;
            tx_q        <= '0;
            msb_q       <= '0;
            lsb_phase_q <= 1'b0;
            ack_q       <= 1'b0;
            sda_low_q   <= 1'b0;
            busy_q      <= 1'b0;
            pointer_q   <= 2'b00;
            config_q    <= CFG_RESET;
            cfg_wr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            tx_q        <= tx_d;
            msb_q       <= msb_d;
            lsb_phase_q <= lsb_phase_d;
            ack_q       <= ack_d;
            sda_low_q   <= sda_low_d;
            busy_q      <= busy_d;
            pointer_q   <= pointer_d;
            config_q    <= config_d;
            cfg_wr_q    <= cfg_wr_d;
        end
    end

    assign sda            = sda_low_q ? 1'b0 : 1'bz;
    assign bus.pointer    = pointer_q;
    assign bus.config_reg = config_rd;
    assign bus.cfg_wr     = cfg_wr_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ads1115_i2c_responder.sv
// Bench for ads1115_i2c_responder: bit-banged I2C master, transaction-level register model,
// and a per-cycle compare of the register outputs against that model.
module tb_ads1115_i2c_responder;

    localparam int Q = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sda_low = 1'b0;
    wire  sda;

    ads1115_i2c_responder_if bus ();

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    ads1115_i2c_responder dut (
        .clk (clk),
        .rst (rst),
        .sda (sda),
        .bus (bus)
    );

    int          n_pass = 0;
    int          n_total = 0;
    int          wr_seen = 0;
    bit          chk_on = 1'b0;
    time         hold_until = 0;

    // Transaction-level model of the target's register view.
    logic [1:0]  exp_pointer = 2'd0;
    logic [15:0] exp_config = 16'h8583;
    logic        exp_busy = 1'b0;
    int          exp_wr = 0;
    int          m_phase = 5;      // 0 addr, 1 pointer, 2 data, 3 read, 4 ignore, 5 idle
    bit          m_have_msb = 1'b0;
    logic [7:0]  m_msb = 8'h00;
    logic [15:0] m_word = 16'h0000;
    int          rd_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic [15:0] model_word(input logic [1:0] p);
        case (p)
            2'd0:    return bus.conv_data;
            2'd1:    return exp_config;
            2'd2:    return 16'h8000;
            default: return 16'h7FFF;
        endcase
    endfunction

    always @(negedge clk) begin
        if (bus.cfg_wr === 1'b1) wr_seen++;
        if (chk_on && $time >= hold_until) begin
            check("cmp_pointer", 32'(bus.pointer), 32'(exp_pointer));
            check("cmp_config", 32'(bus.config_reg), 32'(exp_config));
            check("cmp_busy", 32'(bus.busy), 32'(exp_busy));
            check("cmp_cfg_wr_count", 32'(wr_seen), 32'(exp_wr));
        end
    end

    task automatic quarter();
        repeat (Q) @(negedge clk);
    endtask

    task automatic start_cond();
        sda_low = 1'b0;
        quarter();
        bus.scl = 1'b1;
        quarter();
        sda_low    = 1'b1;
        exp_busy   = 1'b1;
        m_phase    = 0;
        m_have_msb = 1'b0;
        hold_until = $time + 80;
        quarter();
        bus.scl = 1'b0;
        quarter();
    endtask

    task automatic stop_cond();
        sda_low = 1'b1;
        quarter();
        bus.scl = 1'b1;
        quarter();
        sda_low    = 1'b0;
        exp_busy   = 1'b0;
        m_phase    = 5;
        hold_until = $time + 80;
        quarter();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_low = ~b[i];
            quarter();
            bus.scl = 1'b1;
            quarter();
            quarter();
            bus.scl = 1'b0;
            quarter();
        end
        sda_low = 1'b0;
        quarter();
        bus.scl = 1'b1;
        quarter();
        ack = (sda === 1'b0);
        quarter();
        bus.scl    = 1'b0;
        hold_until = $time + (Q + 6) * 10;
        quarter();
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            bus.scl = 1'b1;
            quarter();
            b[i] = (sda !== 1'b0);
            quarter();
            bus.scl = 1'b0;
            quarter();
            quarter();
        end
        sda_low = mack;
        quarter();
        bus.scl = 1'b1;
        quarter();
        quarter();
        bus.scl = 1'b0;
        repeat (2) @(negedge clk);
        sda_low = 1'b0;
        quarter();
    endtask

    // Master write of one byte; ACK expectation and register effects come from the model.
    task automatic send(input logic [7:0] b, input string name);
        logic ack;
        logic exp_ack;
        exp_ack = (m_phase == 0) ? (b[7:1] == 7'h48) : (m_phase == 1 || m_phase == 2);
        write_byte(b, ack);
        check(name, 32'(ack), 32'(exp_ack));
        case (m_phase)
            0: begin
                if (b[7:1] != 7'h48) m_phase = 4;
                else if (b[0]) begin
                    m_phase = 3;
                    m_word  = model_word(exp_pointer);
                    rd_idx  = 0;
                end else m_phase = 1;
            end
            1: begin
                exp_pointer = b[1:0];
                m_have_msb  = 1'b0;
                m_phase     = 2;
            end
            2: begin
                if (!m_have_msb) begin
                    m_msb      = b;
                    m_have_msb = 1'b1;
                end else begin
                    m_have_msb = 1'b0;
                    if (exp_pointer == 2'd1) begin
                        exp_config = {m_msb, b} | 16'h8000;
                        exp_wr++;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic recv(input logic mack, input string name, output logic [7:0] b);
        logic [7:0] exp_b;
        exp_b = (rd_idx % 2 == 0) ? m_word[15:8] : m_word[7:0];
        read_byte(mack, b);
        check(name, 32'(b), 32'(exp_b));
        rd_idx++;
        if (!mack) m_phase = 4;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        logic [7:0] rb;
        bus.scl       = 1'b1;
        bus.conv_data = 16'h1234;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_pointer", 32'(bus.pointer), 32'h0);
        check("rst_config", 32'(bus.config_reg), 32'h8583);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_cfg_wr", 32'(bus.cfg_wr), 32'h0);
        check("rst_sda_released", 32'(sda), 32'h1);
        chk_on = 1'b1;

        // Pointer 1, MSB only, then STOP: no config write.
        start_cond();
        send(8'h90, "a_addr_ack");
        send(8'h01, "a_ptr_ack");
        send(8'hAA, "a_msb_ack");
        stop_cond();
        quarter();
        check("a_config_kept", 32'(bus.config_reg), 32'h8583);
        check("a_no_cfg_wr", 32'(wr_seen), 32'd0);
        check("a_pointer", 32'(bus.pointer), 32'd1);

        // Repeated START after pointer write, then read config.
        start_cond();
        send(8'h90, "b_addr_ack");
        send(8'h01, "b_ptr_ack");
        start_cond();
        send(8'h91, "b_raddr_ack");
        recv(1'b1, "b_rd_msb", rb);
        check("b_lit_msb", 32'(rb), 32'h85);
        recv(1'b0, "b_rd_lsb", rb);
        check("b_lit_lsb", 32'(rb), 32'h83);
        stop_cond();

        // Config write 0x8483.
        start_cond();
        send(8'h90, "c_addr_ack");
        send(8'h01, "c_ptr_ack");
        send(8'h84, "c_msb_ack");
        send(8'h83, "c_lsb_ack");
        stop_cond();
        quarter();
        check("c_lit_config", 32'(bus.config_reg), 32'h8483);
        check("c_lit_one_wr", 32'(wr_seen), 32'd1);
        check("c_lit_pointer", 32'(bus.pointer), 32'd1);

        // OS bit reads back as 1 even when written 0.
        start_cond();
        send(8'h90, "d_addr_ack");
        send(8'h01, "d_ptr_ack");
        send(8'h05, "d_msb_ack");
        send(8'h83, "d_lsb_ack");
        stop_cond();
        quarter();
        check("d_lit_os_forced", 32'(bus.config_reg), 32'h8583);

        // Conversion read at pointer 0.
        start_cond();
        send(8'h90, "e_addr_ack");
        send(8'h00, "e_ptr_ack");
        stop_cond();
        start_cond();
        send(8'h91, "e_raddr_ack");
        recv(1'b1, "e_rd_msb", rb);
        check("e_lit_msb", 32'(rb), 32'h12);
        recv(1'b0, "e_rd_lsb", rb);
        check("e_lit_lsb", 32'(rb), 32'h34);
        stop_cond();
        quarter();
        check("e_busy_after_stop", 32'(bus.busy), 32'h0);
        check("e_sda_released", 32'(sda), 32'h1);

        // Wrong address: NACK, everything after it ignored.
        start_cond();
        send(8'h92, "f_addr_nack");
        send(8'h01, "f_ignored_ptr");
        send(8'h11, "f_ignored_data");
        stop_cond();
        quarter();
        check("f_lit_pointer", 32'(bus.pointer), 32'd0);
        check("f_lit_config", 32'(bus.config_reg), 32'h8583);

        // Pointer 3 threshold read, bytes repeat while ACKed.
        start_cond();
        send(8'h90, "g_addr_ack");
        send(8'h03, "g_ptr_ack");
        start_cond();
        send(8'h91, "g_raddr_ack");
        recv(1'b1, "g_rd_b0", rb);
        check("g_lit_b0", 32'(rb), 32'h7F);
        recv(1'b1, "g_rd_b1", rb);
        check("g_lit_b1", 32'(rb), 32'hFF);
        recv(1'b0, "g_rd_b2", rb);
        check("g_lit_b2", 32'(rb), 32'h7F);
        stop_cond();

        // Reset during read bit 3 of pointer 2 (0x80: bit 3 is driven low).
        start_cond();
        send(8'h90, "h_addr_ack");
        send(8'h02, "h_ptr_ack");
        start_cond();
        send(8'h91, "h_raddr_ack");
        for (int i = 0; i < 3; i++) begin
            bus.scl = 1'b1;
            quarter();
            quarter();
            bus.scl = 1'b0;
            quarter();
            quarter();
        end
        bus.scl = 1'b1;
        quarter();
        check("h_bit3_driven", 32'(sda), 32'h0);
        rst         = 1'b1;
        hold_until  = $time + 100;
        exp_pointer = 2'd0;
        exp_config  = 16'h8583;
        exp_busy    = 1'b0;
        m_phase     = 5;
        @(negedge clk);
        check("h_sda_released", 32'(sda), 32'h1);
        check("h_busy_cleared", 32'(bus.busy), 32'h0);
        check("h_pointer_reset", 32'(bus.pointer), 32'h0);
        check("h_config_reset", 32'(bus.config_reg), 32'h8583);
        rst = 1'b0;
        bus.scl = 1'b0;
        quarter();
        stop_cond();

        // Normal transfer after the reset.
        start_cond();
        send(8'h90, "i_addr_ack");
        send(8'h01, "i_ptr_ack");
        send(8'h12, "i_msb_ack");
        send(8'h34, "i_lsb_ack");
        stop_cond();
        quarter();
        check("i_lit_config", 32'(bus.config_reg), 32'h9234);
        check("i_lit_wr_total", 32'(wr_seen), 32'd3);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
